// File: rtl/magnetron_power_control_if.sv
// Control/status bundle between front-panel/timer logic and the magnetron power control.
//   start_, stop_, clear_ : active-low start/resume, pause, cancel requests
//   door_closed           : 1 = door closed
//   timer_done            : cook timer expired
//   power_level           : requested on-clocks per PWM frame
//   mag_on                : magnetron drive
//   cooking, paused, done : state decodes (done is a one-cycle pulse)
//   state                 : IDLE=00, COOK=01, PAUSE=10, DONE=11
interface magnetron_power_control_if #(
  parameter int unsigned LEVEL_W = 4
);
  logic               start_;
  logic               stop_;
  logic               clear_;
  logic               door_closed;
  logic               timer_done;
  logic [LEVEL_W-1:0] power_level;
  logic               mag_on;
  logic               cooking;
  logic               paused;
  logic               done;
  logic [1:0]         state;

  modport master (
    output start_, stop_, clear_, door_closed, timer_done, power_level,
    input  mag_on, cooking, paused, done, state
  );

  modport slave (
    input  start_, stop_, clear_, door_closed, timer_done, power_level,
    output mag_on, cooking, paused, done, state
  );
endinterface

// File: rtl/magnetron_power_control.sv
// Run/pause/done controller with a duty-cycled magnetron drive: while cooking,
// mag_on is high for level_q out of every PERIOD clocks. The door interlock
// acts combinationally on mag_on.
//   clk    : system clock, rising edge
//   reset_ : asynchronous active-low reset
//   bus    : control inputs and status outputs (slave side)
module magnetron_power_control #(
  parameter int unsigned PERIOD  = 10,
  parameter int unsigned LEVEL_W = 4
) (
  input  logic                      clk,
  input  logic                      reset_,
  magnetron_power_control_if.slave  bus
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COOK  = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [LEVEL_W-1:0] level_q, level_d;

  // State, PWM phase and latched level
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= IDLE;
      pwm_cnt_q <= '0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      pwm_cnt_q <= pwm_cnt_d;
      level_q   <= level_d;
    end
  end

  // Next state; every path into IDLE clears the phase and level
  always_comb begin
    state_d   = state_q;
    pwm_cnt_d = pwm_cnt_q;
    level_d   = level_q;
    unique case (state_q)
      IDLE: begin
        pwm_cnt_d = '0;
        level_d   = '0;
        if (!bus.start_ && bus.door_closed && bus.stop_ && (bus.power_level != '0)) begin
          state_d = COOK;
          // Saturate only here; the level stays fixed for the whole cook
          level_d = (bus.power_level > LEVEL_W'(PERIOD)) ? LEVEL_W'(PERIOD) : bus.power_level;
        end
      end
      COOK: begin
        if (!bus.clear_) begin
          state_d   = IDLE;
          pwm_cnt_d = '0;
          level_d   = '0;
        end else if (!bus.stop_ || !bus.door_closed) begin
          state_d = PAUSE;
        end else if (bus.timer_done) begin
          state_d = DONE;
        end else begin
          pwm_cnt_d = (pwm_cnt_q == CNT_W'(PERIOD - 1)) ? '0 : pwm_cnt_q + CNT_W'(1);
        end
      end
      PAUSE: begin
        // Phase is held so a resumed cook continues mid-frame
        if (!bus.clear_) begin
          state_d   = IDLE;
          pwm_cnt_d = '0;
          level_d   = '0;
        end else if (!bus.start_ && bus.stop_ && bus.door_closed) begin
          state_d = COOK;
        end
      end
      DONE: begin
        state_d   = IDLE;
        pwm_cnt_d = '0;
        level_d   = '0;
      end
      default: begin
        state_d   = IDLE;
        pwm_cnt_d = '0;
        level_d   = '0;
      end
    endcase
  end

  // Drive is gated by the live door input so it drops before the state reacts
  assign bus.mag_on  = (state_q == COOK) && (LEVEL_W'(pwm_cnt_q) < level_q) && bus.door_closed;
  assign bus.cooking = (state_q == COOK);
  assign bus.paused  = (state_q == PAUSE);
  assign bus.done    = (state_q == DONE);
  assign bus.state   = state_q;

endmodule

// File: tb/tb_magnetron_power_control.sv
// Scoreboarded bench for magnetron_power_control: the driver applies stimulus
// on the falling edge and queues the expected post-edge outputs from a frame
// model; a monitor pops and compares after every rising edge.
module tb_magnetron_power_control;

  localparam int unsigned PERIOD  = 10;
  localparam int unsigned LEVEL_W = 4;
  localparam int M_IDLE = 0, M_COOK = 1, M_PAUSE = 2, M_DONE = 3;

  typedef struct packed {
    logic [1:0] st;
    logic       mag;
    logic       cook;
    logic       pause;
    logic       dn;
  } obs_t;

  logic clk;
  logic reset_;
  int   n_cmp;
  int   n_bad;
  obs_t exp_q[$];

  // Reference: cook_ticks counts cooking clocks since start; duty is ticks mod PERIOD
  int m_mode;
  int m_ticks;
  int m_level;

  magnetron_power_control_if #(.LEVEL_W(LEVEL_W)) bus ();

  magnetron_power_control #(.PERIOD(PERIOD), .LEVEL_W(LEVEL_W)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t actual();
    obs_t a;
    a.st    = bus.state;
    a.mag   = bus.mag_on;
    a.cook  = bus.cooking;
    a.pause = bus.paused;
    a.dn    = bus.done;
    return a;
  endfunction

  function automatic obs_t expected(input logic door);
    obs_t e;
    e.st    = 2'(m_mode);
    e.mag   = (m_mode == M_COOK) && ((m_ticks % PERIOD) < m_level) && door;
    e.cook  = (m_mode == M_COOK);
    e.pause = (m_mode == M_PAUSE);
    e.dn    = (m_mode == M_DONE);
    return e;
  endfunction

  function automatic void check(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got st=%b mag=%b cook=%b pause=%b done=%b, want st=%b mag=%b cook=%b pause=%b done=%b",
               name, $time, act.st, act.mag, act.cook, act.pause, act.dn,
               exp.st, exp.mag, exp.cook, exp.pause, exp.dn);
    end
  endfunction

  function automatic void model_reset();
    m_mode  = M_IDLE;
    m_ticks = 0;
    m_level = 0;
  endfunction

  function automatic void model_step(input logic st, sp, cl, dr, td, input int pl);
    case (m_mode)
      M_IDLE: begin
        if (!st && dr && sp && pl != 0) begin
          m_mode  = M_COOK;
          m_level = (pl > PERIOD) ? PERIOD : pl;
          m_ticks = 0;
        end
      end
      M_COOK: begin
        if (!cl)              model_reset();
        else if (!sp || !dr)  m_mode = M_PAUSE;
        else if (td)          m_mode = M_DONE;
        else                  m_ticks++;
      end
      M_PAUSE: begin
        if (!cl)                   model_reset();
        else if (!st && sp && dr)  m_mode = M_COOK;
      end
      default: model_reset();
    endcase
  endfunction

  // One clock of stimulus; also checks the live door gating before the edge
  task automatic drive(input logic st, sp, cl, dr, td, input int pl);
    @(negedge clk);
    bus.start_      = st;
    bus.stop_       = sp;
    bus.clear_      = cl;
    bus.door_closed = dr;
    bus.timer_done  = td;
    bus.power_level = LEVEL_W'(pl);
    #1;
    check("pre_edge_gate", actual(), expected(dr));
    model_step(st, sp, cl, dr, td, pl);
    exp_q.push_back(expected(dr));
  endtask

  task automatic idle_run(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
  endtask

  task automatic start_cook(input int pl);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, pl);
  endtask

  // Monitor: outputs are valid every cycle once a transaction is queued
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check("post_edge", actual(), exp_q.pop_front());
  end

  initial begin
    obs_t zero;
    zero = '0;
    n_cmp = 0;
    n_bad = 0;
    model_reset();
    reset_          = 1'b0;
    bus.start_      = 1'b1;
    bus.stop_       = 1'b1;
    bus.clear_      = 1'b1;
    bus.door_closed = 1'b1;
    bus.timer_done  = 1'b0;
    bus.power_level = '0;
    #12;
    check("reset_state", actual(), zero);
    @(negedge clk);
    reset_ = 1'b1;

    // Door open start ignored, then level 3 frames
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3);
    idle_run(22);

    // Level 5, open the door at phase 3, resume from held phase
    start_cook(5);
    idle_run(3);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5);
    idle_run(12);

    // Completion at full level; timer high for 3 cycles
    start_cook(10);
    idle_run(5);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    idle_run(3);

    // Start held low through DONE
    start_cook(4);
    idle_run(2);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4);
    idle_run(2);

    // Collisions: stop beats timer, clear beats start
    start_cook(7);
    idle_run(2);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 7);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7);
    idle_run(2);
    // In IDLE, start with stop low is ignored
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7);
    idle_run(1);

    // Saturation and zero level
    start_cook(15);
    idle_run(12);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    idle_run(2);

    // Asynchronous reset mid-cook
    start_cook(5);
    idle_run(7);
    @(posedge clk);
    #3;
    reset_ = 1'b0;
    #1;
    check("async_reset", actual(), zero);
    model_reset();
    @(negedge clk);
    check("reset_held", actual(), zero);
    reset_ = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic st, sp, cl, dr, td;
      st = ($urandom_range(0, 3) != 0);
      sp = ($urandom_range(0, 11) != 0);
      cl = ($urandom_range(0, 39) != 0);
      dr = ($urandom_range(0, 15) != 0);
      td = ($urandom_range(0, 24) == 0);
      drive(st, sp, cl, dr, td, int'($urandom_range(0, 15)));
    end

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/magnetron_power_control.md
Name: magnetron_power_control

Overview:
Clocked, parametrised successor to the level-based magnetron enable. Adds a run/pause/done state machine and a duty-cycled power level, so the magnetron is on for power_level out of every PERIOD clocks while cooking. Sits between the front-panel/timer logic and the magnetron driver. Door safety interlock is combinational on the output.

Parameters:
PERIOD, 10, PWM frame length in clocks (>= 2)
LEVEL_W, 4, width of power_level; must satisfy 2^LEVEL_W - 1 >= PERIOD

Ports:
clk  input  1  system clock, rising-edge active
reset_  input  1  asynchronous active-low reset
start_  input  1  active-low start/resume request, synchronous to clk
stop_  input  1  active-low pause request
clear_  input  1  active-low cancel request
door_closed  input  1  1 = door closed
timer_done  input  1  cook timer expired, one or more cycles high
power_level  input  LEVEL_W  requested on-clocks per frame; 0 = off, values above PERIOD saturate to PERIOD
mag_on  output  1  magnetron drive
cooking  output  1  state == COOK
paused  output  1  state == PAUSE
done  output  1  one-cycle pulse on completion
state  output  2  IDLE=00, COOK=01, PAUSE=10, DONE=11

Behaviour:
- Reset (reset_ low, asynchronous):
  - state=IDLE; pwm_cnt=0; level_q=0.
  - mag_on, cooking, paused and done all 0, immediately and independent of clk.
- All inputs are sampled on the rising edge of clk. Each state lists its checks in priority order; the first true condition wins.
- IDLE:
  - start_=0 & door_closed=1 & stop_=1 & power_level!=0 -> COOK. Latch level_q = min(power_level, PERIOD). Set pwm_cnt=0.
  - Anything else -> stay in IDLE. Start with the door open or power 0 is ignored.
- COOK:
  - clear_=0 -> IDLE.
  - stop_=0 or door_closed=0 -> PAUSE.
  - timer_done=1 -> DONE.
  - Otherwise stay in COOK. pwm_cnt increments and wraps from PERIOD-1 to 0.
- PAUSE:
  - pwm_cnt and level_q are held.
  - clear_=0 -> IDLE.
  - start_=0 & stop_=1 & door_closed=1 -> COOK. pwm_cnt resumes from its held value; level_q is not re-latched.
  - timer_done is ignored; the external timer is frozen while paused.
- DONE:
  - Lasts exactly one cycle, then unconditionally -> IDLE.
  - A start_ held low through DONE does not restart cooking until the next IDLE-cycle sample.
- On every entry to IDLE: pwm_cnt=0, level_q=0.
- Outputs:
  - mag_on = (state==COOK) & (pwm_cnt < level_q) & door_closed. The door term is combinational, so mag_on falls in the same cycle the door opens, before the state register updates.
  - cooking, paused and done are decodes of the state register. done=1 only while state==DONE.
- Latency:
  - start_ sampled low at edge k -> cooking=1 and mag_on=1 after edge k (pwm_cnt=0 < level_q).
  - Within each frame, mag_on is high for pwm_cnt 0..level_q-1 and low for level_q..PERIOD-1.
  - level_q==PERIOD gives continuous mag_on.
- Simultaneous events:
  - clear beats everything.
  - In IDLE, start_ with stop_ low is ignored.
  - In COOK, stop or door-open beats timer_done, so the state goes to PAUSE, not DONE.
- Arithmetic:
  - pwm_cnt width is the minimum needed to hold PERIOD-1.
  - The comparison against level_q is unsigned at LEVEL_W bits.
  - Saturation is applied only at latch time.

Test Plan:
- Reset mid-cook: PERIOD=10, power_level=5, cook 7 cycles, pulse reset_ low between clock edges -> mag_on, cooking and state go to 0 immediately without a clock edge.
- Door-open start: door_closed=0, start_ low 1 cycle -> state stays 00, mag_on=0. Then door_closed=1 and start_ pulse with power_level=3 -> state=01. mag_on pattern is 1,1,1,0,0,0,0,0,0,0 repeating per 10-clock frame.
- Pause/resume with held phase: level 5; open the door at pwm_cnt=3 -> mag_on=0 in the same cycle, state=10 next edge. Close the door, start_ pulse -> COOK resumes with mag_on for cnt 3,4, then low for 5..9.
- Completion: COOK at level 10, timer_done=1 for 3 cycles -> mag_on continuously 1 until the edge that samples timer_done, then done=1 for exactly one cycle, then state=00, mag_on=0.
- Priority collisions:
  - In COOK, assert timer_done and stop_=0 on the same edge -> state=10, done stays 0.
  - In PAUSE, assert clear_=0 and start_=0 on the same edge -> state=00.
- Saturation and zero:
  - power_level=15 with PERIOD=10 -> mag_on constantly 1 in COOK.
  - power_level=0 with start_ low -> state stays 00.
